lcd_timing_gen: RTL
===================

Name: lcd_timing_gen

Overview:
- Parametrised RGB-LCD timing and test-pattern generator for the nano-LCD panels.
- Generalises the fixed 480x272 VGA-style driver to configurable porch, sync, polarity, colour width and pixel-clock divide.
- Runs on the single system clock and derives the pixel clock internally from a clock enable, so no PLL divided output is needed.
- Adds selectable test patterns, a frame-start strobe and a frame counter for bring-up and for the PLL/LCD examples.

Parameters:
- CLK_DIV, 10: system clocks per pixel; must be >= 2.
- H_ACTIVE, 480: visible pixels per line.
- H_FP, 8: horizontal front porch, in pixels.
- H_SYNC, 4: hsync pulse width, in pixels.
- H_BP, 43: horizontal back porch, in pixels.
- V_ACTIVE, 272: visible lines per frame.
- V_FP, 8: vertical front porch, in lines.
- V_SYNC, 4: vsync pulse width, in lines.
- V_BP, 12: vertical back porch, in lines.
- HS_POL, 0: active level of hsync (0 = active low).
- VS_POL, 0: active level of vsync (0 = active low).
- R_W, 5: red channel width.
- G_W, 6: green channel width.
- B_W, 5: blue channel width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- enable  in  1  run timing; when low, outputs are held idle.
- pattern_sel  in  3  test pattern select.
- solid_rgb  in  R_W+G_W+B_W  colour for the solid pattern; packed {R,G,B}.
- lcd_clk  out  1  pixel clock to the panel.
- lcd_de  out  1  data enable.
- lcd_hsync  out  1  horizontal sync.
- lcd_vsync  out  1  vertical sync.
- lcd_r  out  R_W  red.
- lcd_g  out  G_W  green.
- lcd_b  out  B_W  blue.
- frame_start  out  1  one-clk pulse at the start of each frame.
- frame_count  out  16  frames started since reset.

Behaviour:
- Single clock clk. Synchronous active-high reset rst.
- Reset and idle state:
  - Reset values: div_cnt=0, h_cnt=0, v_cnt=0, lcd_clk=0, lcd_de=0.
  - lcd_hsync=~HS_POL and lcd_vsync=~VS_POL.
  - RGB=0, frame_start=0, frame_count=0, latched pattern=0.
- Pixel clock divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is asserted when div_cnt==CLK_DIV-1.
  - lcd_clk = registered (div_cnt >= CLK_DIV/2), so its rising edge falls mid-pixel and data is stable.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - On pix_en, h_cnt increments and wraps at H_TOTAL-1 to 0.
  - On that wrap, v_cnt increments and wraps at V_TOTAL-1 to 0.
  - Counter widths are $clog2 of the totals.
- Segment order per line: active, front porch, sync, back porch. The same order applies per frame.
- Output timing:
  - All outputs are registered on pix_en from the current (h_cnt, v_cnt), giving a latency of 1 pixel period.
  - DE = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hsync is active while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active for the analogous v_cnt range, for whole lines.
  - RGB is forced to 0 whenever DE=0.
- Patterns (x=h_cnt, y=v_cnt). pattern_sel is latched only at h=0,v=0 so patterns never tear.
  - 0 colour bars: 8 bars, boundaries at floor(k*H_ACTIVE/8). Order: white, yellow, cyan, green, magenta, red, blue, black.
  - 1 grid: white if x[3:0]==0 or y[3:0]==0, else black.
  - 2 gradient: each channel = x[msb-aligned to channel width]. Channel width is at most 8 bits and taken from x[8:..].
  - 3 solid: solid_rgb.
  - 4 checker: white if x[4]^y[4], else black.
  - 5-7: black.
- Frame events:
  - At the pix_en where h=0,v=0, frame_start pulses high for exactly 1 clk.
  - frame_count increments in that same cycle and wraps 0xFFFF->0.
- enable:
  - enable=0 synchronously resets div_cnt/h/v and forces the reset-idle outputs.
  - frame_count holds its value.
  - On the next cycle with enable=1, timing restarts at h=0,v=0 and the first pix_en generates frame_start.
- Reset mid-frame: the next cycle is the idle state regardless of position. No partial-line completion.
- Simultaneous rst and enable: rst wins.

Decomposition:
- Package lcd_timing_pkg:
  - pattern_e enum: BARS, GRID, GRAD, SOLID, CHECK.
  - 8 bar colour constants as 8-bit RGB, truncated MSB-first to R_W/G_W/B_W.
  - Function for $clog2-safe counter width.
- Sub-module lcd_pattern_gen (combinational): inputs x, y, latched pattern, solid_rgb; output RGB.
- Top holds the divider, counters, syncs, output registers and frame logic.

Test Plan:
- Reduced params for all scenarios unless stated: CLK_DIV=2; H 16/2/2/2 (H_TOTAL=22); V 8/1/1/2 (V_TOTAL=12); HS_POL=VS_POL=0.
- Reset release, enable=1:
  - lcd_clk period is 2 clk.
  - frame_start pulses 1 clk and recurs every 22*12*2=528 clk.
  - frame_count goes 0->1->2.
- Line timing:
  - DE is high for 16 pixels per line, during lines 0..7 only.
  - hsync is low exactly for pixels 18-19.
  - vsync is low for all of line 9.
  - RGB=0 whenever DE=0.
- pattern_sel=0: pixels 0-1 = white (1F,3F,1F), pixels 2-3 = yellow (1F,3F,00), pixels 14-15 = black.
- Pattern latching: pattern_sel changed 0->3 mid-frame with solid_rgb=16'hF800. The current frame stays colour bars; the next frame is all DE pixels R=1F, G=0, B=0.
- enable dropped mid-line 4:
  - The next cycle shows DE=0, hsync=vsync=1, lcd_clk=0.
  - frame_count is held.
  - On re-enable, frame_start fires on the first pix_en and frame_count increments.
- rst asserted mid-frame (default params), plus wrap:
  - All outputs reach reset values in 1 cycle.
  - Force frame_count to 0xFFFF via 65535 frames in a fast-frame config; the next frame_start wraps it to 0.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_timing_pkg : pattern codes, bar colours, counter width helper    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package lcd_timing_pkg;

  typedef enum logic [2:0] {
    BARS  = 3'd0,
    GRID  = 3'd1,
    GRAD  = 3'd2,
    SOLID = 3'd3,
    CHECK = 3'd4
  } pattern_e;

  localparam logic [23:0] C_WHITE   = 24'hFF_FF_FF;
  localparam logic [23:0] C_YELLOW  = 24'hFF_FF_00;
  localparam logic [23:0] C_CYAN    = 24'h00_FF_FF;
  localparam logic [23:0] C_GREEN   = 24'h00_FF_00;
  localparam logic [23:0] C_MAGENTA = 24'hFF_00_FF;
  localparam logic [23:0] C_RED     = 24'hFF_00_00;
  localparam logic [23:0] C_BLUE    = 24'h00_00_FF;
  localparam logic [23:0] C_BLACK   = 24'h00_00_00;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      3'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

  // $clog2(1) is 0, which would give a zero-width counter
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_pattern_gen : combinational test-pattern colour for pixel (x,y)  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module lcd_pattern_gen
  import lcd_timing_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int H_ACTIVE = 480,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5
) (
  input  logic [X_W-1:0]         x,
  input  logic [Y_W-1:0]         y,
  input  logic [2:0]             pattern,
  input  logic [R_W+G_W+B_W-1:0] solid_rgb,
  output logic [R_W-1:0]         r,
  output logic [G_W-1:0]         g,
  output logic [B_W-1:0]         b
);

  logic [8:0]     w_x9;
  logic [2:0]     w_bar;
  logic [23:0]    w_rgb24;
  logic           w_direct;
  logic [R_W-1:0] w_dr;
  logic [G_W-1:0] w_dg;
  logic [B_W-1:0] w_db;

  assign w_x9 = 9'(x);

  always_comb begin
    w_rgb24  = C_BLACK;
    w_direct = 1'b0;
    w_dr     = '0;
    w_dg     = '0;
    w_db     = '0;
    w_bar    = 3'd0;
    // bar k starts at floor(k*H_ACTIVE/8); the last boundary passed wins
    for (int k = 1; k < 8; k++) begin
      if (int'(x) >= (k * H_ACTIVE) / 8) w_bar = 3'(k);
    end
    case (pattern_e'(pattern))
      BARS:  w_rgb24 = bar_colour(w_bar);
      GRID:  if ((int'(x) % 16 == 0) || (int'(y) % 16 == 0)) w_rgb24 = C_WHITE;
      GRAD: begin
        w_direct = 1'b1;
        w_dr     = w_x9[8 -: R_W];
        w_dg     = w_x9[8 -: G_W];
        w_db     = w_x9[8 -: B_W];
      end
      SOLID: begin
        w_direct         = 1'b1;
        {w_dr, w_dg, w_db} = solid_rgb;
      end
      CHECK: if ((((int'(x) >> 4) ^ (int'(y) >> 4)) & 1) != 0) w_rgb24 = C_WHITE;
      default: w_rgb24 = C_BLACK;
    endcase
  end

  assign r = w_direct ? w_dr : w_rgb24[23 -: R_W];
  assign g = w_direct ? w_dg : w_rgb24[15 -: G_W];
  assign b = w_direct ? w_db : w_rgb24[7  -: B_W];

endmodule
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_timing_gen : RGB-LCD timing, test patterns and frame events      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int CLK_DIV  = 10,
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 43,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [2:0]             pattern_sel,
  input  logic [R_W+G_W+B_W-1:0] solid_rgb,
  output logic                   lcd_clk,
  output logic                   lcd_de,
  output logic                   lcd_hsync,
  output logic                   lcd_vsync,
  output logic [R_W-1:0]         lcd_r,
  output logic [G_W-1:0]         lcd_g,
  output logic [B_W-1:0]         lcd_b,
  output logic                   frame_start,
  output logic [15:0]            frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = cnt_width(H_TOTAL);
  localparam int V_W     = cnt_width(V_TOTAL);
  localparam int DIV_W   = cnt_width(CLK_DIV);

  localparam logic C_HS_ACT  = (HS_POL != 0);
  localparam logic C_VS_ACT  = (VS_POL != 0);
  localparam logic C_HS_IDLE = ~C_HS_ACT;
  localparam logic C_VS_IDLE = ~C_VS_ACT;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [H_W-1:0]   h_cnt_q, h_cnt_d;
  logic [V_W-1:0]   v_cnt_q, v_cnt_d;
  logic             lcd_clk_q, lcd_clk_d;
  logic             de_q, de_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic [R_W-1:0]   r_q, r_d;
  logic [G_W-1:0]   g_q, g_d;
  logic [B_W-1:0]   b_q, b_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic [2:0]       pattern_q, pattern_d;

  logic             w_pix_en;
  logic             w_origin;
  logic [2:0]       w_pat_eff;
  logic             w_de;
  logic             w_hs_act;
  logic             w_vs_act;
  logic [R_W-1:0]   w_r;
  logic [G_W-1:0]   w_g;
  logic [B_W-1:0]   w_b;

  assign w_pix_en = (int'(div_cnt_q) == CLK_DIV - 1);
  assign w_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  // Pixel (0,0) already uses the newly latched select so a frame never mixes two patterns
  assign w_pat_eff = w_origin ? pattern_sel : pattern_q;

  assign w_de     = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
  assign w_hs_act = (int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                    (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
  assign w_vs_act = (int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                    (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);

  lcd_pattern_gen #(
    .X_W      (H_W),
    .Y_W      (V_W),
    .H_ACTIVE (H_ACTIVE),
    .R_W      (R_W),
    .G_W      (G_W),
    .B_W      (B_W)
  ) u_pattern (
    .x         (h_cnt_q),
    .y         (v_cnt_q),
    .pattern   (w_pat_eff),
    .solid_rgb (solid_rgb),
    .r         (w_r),
    .g         (w_g),
    .b         (w_b)
  );

  always_comb begin
    div_cnt_d     = div_cnt_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    lcd_clk_d     = lcd_clk_q;
    de_d          = de_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    pattern_d     = pattern_q;

    if (!enable) begin
      div_cnt_d = '0;
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      lcd_clk_d = 1'b0;
      de_d      = 1'b0;
      hs_d      = C_HS_IDLE;
      vs_d      = C_VS_IDLE;
      r_d       = '0;
      g_d       = '0;
      b_d       = '0;
    end else begin
      // high for the second half of each pixel so the panel samples mid-pixel
      lcd_clk_d = (int'(div_cnt_q) >= CLK_DIV / 2);
      div_cnt_d = w_pix_en ? '0 : div_cnt_q + DIV_W'(1);
      if (w_pix_en) begin
        if (int'(h_cnt_q) == H_TOTAL - 1) begin
          h_cnt_d = '0;
          v_cnt_d = (int'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + V_W'(1);
        end else begin
          h_cnt_d = h_cnt_q + H_W'(1);
        end
        de_d = w_de;
        hs_d = w_hs_act ? C_HS_ACT : C_HS_IDLE;
        vs_d = w_vs_act ? C_VS_ACT : C_VS_IDLE;
        r_d  = w_de ? w_r : '0;
        g_d  = w_de ? w_g : '0;
        b_d  = w_de ? w_b : '0;
        if (w_origin) begin
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          pattern_d     = pattern_sel;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      lcd_clk_q     <= 1'b0;
      de_q          <= 1'b0;
      hs_q          <= C_HS_IDLE;
      vs_q          <= C_VS_IDLE;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      pattern_q     <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      lcd_clk_q     <= lcd_clk_d;
      de_q          <= de_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      pattern_q     <= pattern_d;
    end
  end

  assign lcd_clk     = lcd_clk_q;
  assign lcd_de      = de_q;
  assign lcd_hsync   = hs_q;
  assign lcd_vsync   = vs_q;
  assign lcd_r       = r_q;
  assign lcd_g       = g_q;
  assign lcd_b       = b_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire
